// File: rtl/fetch_stage.sv
// IF stage: PC register, single-outstanding instruction fetch, IF/ID pipeline register.
// Handles variable imem latency, decode stalls (hold buffer) and flush/redirect (drop flag).
//
// state  | meaning
// S_REQ  | request imem_addr=pc_o, wait for grant
// S_WAIT | granted, waiting for imem_rvalid (data dropped if drop_q set)
// S_HOLD | data captured in hold buffer, waiting for stall to release
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_o,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc8,
    output logic        if_id_adel,
    output logic        fetch_busy
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

    // The exception vector is supplied by the pipeline; only sanity-check it here.
    if (EXC_PC[1:0] != 2'b00) begin : g_exc_pc_check
        $error("fetch_stage: EXC_PC must be word aligned");
    end

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        mis_q, mis_d;
    logic        drop_q, drop_d;
    logic [31:0] hold_q, hold_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic [31:0] ipc8_q, ipc8_d;
    logic        adel_q, adel_d;
    logic        deliver;
    logic [31:0] dlv_instr;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        mis_d     = mis_q;
        drop_d    = drop_q;
        hold_d    = hold_q;
        deliver   = 1'b0;
        dlv_instr = hold_q;

        case (state_q)
            S_REQ: begin
                if (!flush && imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q || flush) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (!stall) begin
                        deliver   = 1'b1;
                        dlv_instr = imem_rdata;
                        state_d   = S_REQ;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    state_d = S_REQ;
                end else if (!stall) begin
                    deliver = 1'b1;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (flush) begin
            pc_d  = {redirect_pc[31:2], 2'b00};
            mis_d = |redirect_pc[1:0];
        end else if (deliver) begin
            pc_d  = {npc[31:2], 2'b00};
            mis_d = |npc[1:0];
        end

        // flush beats stall; an unstalled cycle without delivery inserts a bubble
        valid_d = flush ? 1'b0 : (stall ? valid_q : deliver);
        instr_d = deliver ? dlv_instr : instr_q;
        ipc_d   = deliver ? pc_q : ipc_q;
        ipc8_d  = deliver ? pc_q + 32'd8 : ipc8_q;
        adel_d  = deliver ? mis_q : adel_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            mis_q   <= 1'b0;
            drop_q  <= 1'b0;
            hold_q  <= 32'd0;
            valid_q <= 1'b0;
            instr_q <= 32'd0;
            ipc_q   <= 32'd0;
            ipc8_q  <= 32'd0;
            adel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
            drop_q  <= drop_d;
            hold_q  <= hold_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            ipc8_q  <= ipc8_d;
            adel_q  <= adel_d;
        end
    end

    assign imem_req    = (state_q == S_REQ) && !flush;
    assign imem_addr   = pc_q;
    assign pc_o        = pc_q;
    assign if_id_valid = valid_q;
    assign if_id_instr = instr_q;
    assign if_id_pc    = ipc_q;
    assign if_id_pc8   = ipc8_q;
    assign if_id_adel  = adel_q;
    assign fetch_busy  = (state_q != S_REQ);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: one task per scenario, inline comparisons.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] npc;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_o;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc8;
    logic        if_id_adel;
    logic        fetch_busy;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .npc(npc), .stall(stall), .flush(flush),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .pc_o(pc_o), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_pc8(if_id_pc8), .if_id_adel(if_id_adel),
        .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (pc_o !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc_o, 32'h3000); end
        checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_id_valid); end
        checks++; if (if_id_instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected 0", if_id_instr); end
        checks++; if (if_id_pc8 !== 32'd0) begin errors++; $display("FAIL reset_pc8: got %h expected 0", if_id_pc8); end
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", fetch_busy); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b expected 1", imem_req); end
    endtask

    task automatic test_basic();
        logic [31:0] exp_pc;
        logic [31:0] instr;
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'h3000 + 32'(4 * i);
            instr  = 32'h2401_0001 + 32'(i);
            checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL basic_req[%0d]: got %b expected 1", i, imem_req); end
            checks++; if (imem_addr !== exp_pc) begin errors++; $display("FAIL basic_addr[%0d]: got %h expected %h", i, imem_addr, exp_pc); end
            imem_gnt = 1'b1;
            tick();
            imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = instr; npc = exp_pc + 32'd4;
            #1;
            checks++; if (imem_req !== 1'b0 || fetch_busy !== 1'b1) begin errors++; $display("FAIL basic_wait[%0d]: req %b busy %b expected 0 1", i, imem_req, fetch_busy); end
            tick();
            imem_rvalid = 1'b0;
            checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %b expected 1", i, if_id_valid); end
            checks++; if (if_id_pc !== exp_pc) begin errors++; $display("FAIL basic_ifpc[%0d]: got %h expected %h", i, if_id_pc, exp_pc); end
            checks++; if (if_id_pc8 !== exp_pc + 32'd8) begin errors++; $display("FAIL basic_pc8[%0d]: got %h expected %h", i, if_id_pc8, exp_pc + 32'd8); end
            checks++; if (if_id_instr !== instr) begin errors++; $display("FAIL basic_instr[%0d]: got %h expected %h", i, if_id_instr, instr); end
            checks++; if (pc_o !== exp_pc + 32'd4) begin errors++; $display("FAIL basic_pcnext[%0d]: got %h expected %h", i, pc_o, exp_pc + 32'd4); end
        end
    endtask

    task automatic test_delay();
        checks++; if (imem_addr !== 32'h300C) begin errors++; $display("FAIL delay_addr: got %h expected %h", imem_addr, 32'h300C); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; npc = 32'h3010;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (pc_o !== 32'h300C) begin errors++; $display("FAIL delay_pc[%0d]: got %h expected %h", k, pc_o, 32'h300C); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL delay_req[%0d]: got %b expected 0", k, imem_req); end
            checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL delay_bubble[%0d]: got %b expected 0", k, if_id_valid); end
        end
        imem_rvalid = 1'b1; imem_rdata = 32'h2402_0002;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (if_id_valid !== 1'b1 || if_id_instr !== 32'h2402_0002) begin errors++; $display("FAIL delay_deliver: valid %b instr %h expected 1 24020002", if_id_valid, if_id_instr); end
        checks++; if (pc_o !== 32'h3010) begin errors++; $display("FAIL delay_pcnext: got %h expected %h", pc_o, 32'h3010); end
    endtask

    task automatic test_stall();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        stall = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h8C01_0004; npc = 32'h3014;
        tick();
        imem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (fetch_busy !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_hold_state[%0d]: busy %b req %b expected 1 0", k, fetch_busy, imem_req); end
            checks++; if (if_id_instr !== 32'h2402_0002 || if_id_pc !== 32'h300C || if_id_valid !== 1'b0) begin errors++; $display("FAIL stall_ifid[%0d]: instr %h pc %h valid %b expected 24020002 0000300c 0", k, if_id_instr, if_id_pc, if_id_valid); end
            checks++; if (pc_o !== 32'h3010) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected %h", k, pc_o, 32'h3010); end
            tick();
        end
        stall = 1'b0;
        tick();
        checks++; if (if_id_instr !== 32'h8C01_0004 || if_id_valid !== 1'b1) begin errors++; $display("FAIL stall_release: instr %h valid %b expected 8c010004 1", if_id_instr, if_id_valid); end
        checks++; if (if_id_pc !== 32'h3010 || pc_o !== 32'h3014) begin errors++; $display("FAIL stall_release_pc: ifpc %h pc_o %h expected 00003010 00003014", if_id_pc, pc_o); end
        checks++; if (fetch_busy !== 1'b0) begin errors++; $display("FAIL stall_release_busy: got %b expected 0", fetch_busy); end
    endtask

    task automatic test_flush();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        flush = 1'b1; redirect_pc = 32'h4180;
        tick();
        flush = 1'b0;
        checks++; if (pc_o !== 32'h4180 || imem_req !== 1'b0 || fetch_busy !== 1'b1) begin errors++; $display("FAIL flush_wait: pc %h req %b busy %b expected 00004180 0 1", pc_o, imem_req, fetch_busy); end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; npc = 32'h1234;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h8C01_0004) begin errors++; $display("FAIL flush_stale: valid %b instr %h expected 0 8c010004", if_id_valid, if_id_instr); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4180) begin errors++; $display("FAIL flush_redirect: req %b addr %h expected 1 00004180", imem_req, imem_addr); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_000C; npc = 32'h3006;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (if_id_pc !== 32'h4180 || if_id_adel !== 1'b0 || pc_o !== 32'h3004) begin errors++; $display("FAIL flush_fetch: ifpc %h adel %b pc_o %h expected 00004180 0 00003004", if_id_pc, if_id_adel, pc_o); end
    endtask

    task automatic test_misalign();
        checks++; if (imem_addr !== 32'h3004) begin errors++; $display("FAIL adel_addr: got %h expected %h", imem_addr, 32'h3004); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h03E0_0008; npc = 32'h3008;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (if_id_adel !== 1'b1 || if_id_pc !== 32'h3004) begin errors++; $display("FAIL adel_flag: adel %b pc %h expected 1 00003004", if_id_adel, if_id_pc); end
        checks++; if (if_id_pc8 !== 32'h300C || pc_o !== 32'h3008) begin errors++; $display("FAIL adel_next: pc8 %h pc_o %h expected 0000300c 00003008", if_id_pc8, pc_o); end
    endtask

    task automatic test_wrap();
        flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL wrap_flush_req: got %b expected 0", imem_req); end
        tick();
        flush = 1'b0;
        checks++; if (pc_o !== 32'hFFFF_FFFC || fetch_busy !== 1'b0) begin errors++; $display("FAIL wrap_pc: pc %h busy %b expected fffffffc 0", pc_o, fetch_busy); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_2222; npc = 32'h5000;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (if_id_pc8 !== 32'h0000_0004 || if_id_adel !== 1'b0) begin errors++; $display("FAIL wrap_pc8: pc8 %h adel %b expected 00000004 0", if_id_pc8, if_id_adel); end
        checks++; if (pc_o !== 32'h5000) begin errors++; $display("FAIL wrap_pcnext: got %h expected %h", pc_o, 32'h5000); end
    endtask

    task automatic test_reset_mid();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++; if (pc_o !== 32'h3000 || fetch_busy !== 1'b0) begin errors++; $display("FAIL rstmid_pc: pc %h busy %b expected 00003000 0", pc_o, fetch_busy); end
        checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'd0 || if_id_pc !== 32'd0 || if_id_pc8 !== 32'd0 || if_id_adel !== 1'b0) begin errors++; $display("FAIL rstmid_ifid: valid %b instr %h pc %h pc8 %h adel %b expected all zero", if_id_valid, if_id_instr, if_id_pc, if_id_pc8, if_id_adel); end
        @(negedge clk);
        reset = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0; npc = 32'h7000;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (if_id_valid !== 1'b0 || pc_o !== 32'h3000 || fetch_busy !== 1'b0) begin errors++; $display("FAIL rstmid_late: valid %b pc %h busy %b expected 0 00003000 0", if_id_valid, pc_o, fetch_busy); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin errors++; $display("FAIL rstmid_req: req %b addr %h expected 1 00003000", imem_req, imem_addr); end
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2403_0003; npc = 32'h3004;
        tick();
        imem_rvalid = 1'b0;
        checks++; if (if_id_pc !== 32'h3000 || if_id_instr !== 32'h2403_0003 || if_id_valid !== 1'b1) begin errors++; $display("FAIL rstmid_refetch: pc %h instr %h valid %b expected 00003000 24030003 1", if_id_pc, if_id_instr, if_id_valid); end
    endtask

    initial begin
        reset = 1'b0; npc = 32'd0; stall = 1'b0; flush = 1'b0; redirect_pc = 32'd0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        test_reset();
        @(negedge clk);
        reset = 1'b1;
        tick();
        test_basic();
        test_delay();
        test_stall();
        test_flush();
        test_misalign();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline: owns the PC register, issues one instruction-memory request at a time and registers the fetched word into the IF/ID pipeline register.
- Sits directly upstream of the next-PC logic: drives `pc_o` into it and latches its `npc` result when the fetched instruction advances.
- Absorbs variable imem latency and decode-stage stalls, and discards in-flight fetches on redirect/flush.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
EXC_PC, 32'h0000_4180, redirect target reported for misaligned fetch (informational; the pipeline supplies the actual redirect)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
npc  input  32  next PC from next-PC logic, valid every cycle
stall  input  1  hazard-unit stall of IF/ID (1 = hold)
flush  input  1  kill IF/ID contents and redirect fetch
redirect_pc  input  32  new PC, used when flush=1
imem_req  output  1  fetch request
imem_addr  output  32  word address for request (= pc_o)
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  read data valid
imem_rdata  input  32  instruction word
pc_o  output  32  current fetch PC, to next-PC logic
if_id_valid  output  1  IF/ID holds a real instruction
if_id_instr  output  32  fetched instruction
if_id_pc  output  32  PC of if_id_instr
if_id_pc8  output  32  if_id_pc + 8 (jal link value)
if_id_adel  output  1  instruction fetched from misaligned npc (AdEL)
fetch_busy  output  1  1 while a request is outstanding or buffered

Behaviour:
- Reset values (async, reset=0):
  - pc_o=RESET_PC, state=S_REQ, all if_id_* = 0 (if_id_pc8=0), drop=0, hold buffer=0, misalign flag=0.
- States:
  - S_REQ: imem_req=1 unless flush=1. imem_addr=pc_o. req&&gnt -> S_WAIT, else stay.
  - S_WAIT: wait for imem_rvalid.
    - If drop=1: discard data, clear drop, -> S_REQ.
    - Else if stall=0: IF/ID <= {1, rdata, pc_o, pc_o+8, misalign}; pc_o <= {npc[31:2],2'b00}; misalign <= |npc[1:0]; -> S_REQ.
    - Else: rdata -> hold buffer, -> S_HOLD.
  - S_HOLD: when stall=0, load IF/ID from hold buffer (same fields), update pc_o from npc as above, -> S_REQ.
- Minimum fetch latency: 2 cycles per instruction with a 1-cycle imem (req/gnt cycle, then rvalid cycle). No back-to-back overlap; one outstanding request max.
- IF/ID update rules (flush has priority over stall):
  - stall=1: IF/ID holds its value.
  - stall=0 and no instruction delivered this cycle: if_id_valid <= 0 (bubble). The other IF/ID fields hold their value.
- flush=1:
  - if_id_valid <= 0; pc_o <= {redirect_pc[31:2],2'b00}; misalign <= |redirect_pc[1:0].
  - S_REQ: no request this cycle, stays in S_REQ.
  - S_WAIT with rvalid=0: drop <= 1, stays in S_WAIT.
  - S_WAIT with rvalid=1: data discarded, -> S_REQ.
  - S_HOLD: buffer discarded, -> S_REQ.
- flush and stall together: flush wins.
- pc_o never advances except on delivery or flush. pc_o[1:0] is always 0.
- imem_rvalid outside S_WAIT is ignored.
- pc+8 wraps modulo 2^32.
- fetch_busy = (state != S_REQ).
- Reset asserted mid-transaction returns to S_REQ immediately. A late rvalid after reset release is ignored because state is S_REQ.

Test Plan:
- Reset release, 1-cycle imem, stall=0, npc=pc_o+4:
  - Required: imem_addr sequence 0x3000, 0x3004, 0x3008 every 2 cycles.
  - Required: if_id_pc=0x3000, if_id_pc8=0x3008, if_id_valid=1 one cycle after first rvalid.
- imem rvalid delayed 3 cycles:
  - Required: pc_o stays 0x3000 and imem_req=0 during the wait.
  - Required: if_id_valid=0 bubble until delivery.
- stall=1 held for 4 cycles while data returns with instr 0x8C010004:
  - Required: IF/ID unchanged and state S_HOLD.
  - Required: on stall release, if_id_instr=0x8C010004 and pc_o <= npc.
- flush with redirect_pc=0x4180 while in S_WAIT, then stale rvalid arrives:
  - Required: stale data discarded and if_id_valid=0.
  - Required: next imem_addr=0x4180.
- npc=0x3006:
  - Required: imem_addr=0x3004 and that instruction arrives with if_id_adel=1.
- Async reset asserted mid-S_WAIT:
  - Required: outputs return to their reset values immediately.
  - Required: a following rvalid is ignored and the first request is to 0x3000.
